arith_op_sequencer: RTL

ARITH_OP_SEQUENCER -- requirements
Module: arith_op_sequencer

---
 rtl/arith_seq_pkg.sv | 15 +
 rtl/arith_op_sequencer_if.sv | 41 ++++
 rtl/arith_op_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/arith_seq_pkg.sv
// Shared definitions for the arithmetic operation sequencer.
// Holds the FSM state encoding and the fixed field widths.
package arith_seq_pkg;

  localparam int OP_W     = 4;
  localparam int STATUS_W = 4;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/arith_op_sequencer_if.sv
// Handshake/bus bundle between the sequencer, its command source,
// the arithmetic unit beside it and the response consumer.
// slave  : the sequencer's view.
// master : the surrounding environment's view.
interface arith_op_sequencer_if
  import arith_seq_pkg::*;
#(
  parameter int M = 32
);

  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [M-1:0]        i_cmd_A;
  logic [M-1:0]        i_cmd_B;
  logic [OP_W-1:0]     i_cmd_op;
  logic [M-1:0]        o_arg_A;
  logic [M-1:0]        o_arg_B;
  logic [OP_W-1:0]     o_op;
  logic [M-1:0]        i_result;
  logic [STATUS_W-1:0] i_status;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [M-1:0]        o_rsp_result;
  logic [STATUS_W-1:0] o_rsp_status;
  logic                o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_A, i_cmd_B, i_cmd_op,
    input  i_result, i_status, i_rsp_ready,
    output o_cmd_ready, o_arg_A, o_arg_B, o_op,
    output o_rsp_valid, o_rsp_result, o_rsp_status, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_A, i_cmd_B, i_cmd_op,
    output i_result, i_status, i_rsp_ready,
    input  o_cmd_ready, o_arg_A, o_arg_B, o_op,
    input  o_rsp_valid, o_rsp_result, o_rsp_status, o_busy
  );

endinterface

// File: rtl/arith_op_sequencer.sv
// Arithmetic operation sequencer: accepts one command, drives it to an
// external arithmetic unit, waits LAT edges, captures result/status and
// holds the response until the consumer takes it.
// Optional feature: define ARITH_SEQ_STATUS_CNT_EN to add o_flag_count,
// a saturating count of responses carrying non-zero status.
module arith_op_sequencer
  import arith_seq_pkg::*;
#(
  parameter int M   = 32,
  parameter int LAT = 1
)(
  input  logic                 clk,
  input  logic                 i_reset,
  arith_op_sequencer_if.slave  io_bus
`ifdef ARITH_SEQ_STATUS_CNT_EN
  ,
  output logic [15:0]          o_flag_count
`endif
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [M-1:0]        r_arg_A;
  logic [M-1:0]        r_arg_B;
  logic [OP_W-1:0]     r_op;
  logic [M-1:0]        r_rsp_result;
  logic [STATUS_W-1:0] r_rsp_status;
  logic                r_rsp_valid;
  logic                w_accept;
  logic                w_capture;
  logic                w_rsp_hs;

  // State register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode and the three events that move data.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_hs     = 1'b0;
    case (r_state)
      IDLE: if (io_bus.i_cmd_valid) begin
        w_accept     = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: if (r_cnt == CNT_W'(1)) begin
        w_capture    = 1'b1;
        w_next_state = RESP;
      end
      RESP: if (io_bus.i_rsp_ready) begin
        w_rsp_hs     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset)            r_cnt <= '0;
    else if (w_accept)       r_cnt <= LAT_CNT;
    else if (r_state == WAIT) r_cnt <= r_cnt - CNT_W'(1);
  end

  // Operand/opcode registers hold the last accepted command.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_arg_A <= '0;
      r_arg_B <= '0;
      r_op    <= '0;
    end else if (w_accept) begin
      r_arg_A <= io_bus.i_cmd_A;
      r_arg_B <= io_bus.i_cmd_B;
      r_op    <= io_bus.i_cmd_op;
    end
  end

  // Response capture and valid flag, cleared by the consumer handshake.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rsp_result <= '0;
      r_rsp_status <= '0;
      r_rsp_valid  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result <= io_bus.i_result;
      r_rsp_status <= io_bus.i_status;
      r_rsp_valid  <= 1'b1;
    end else if (w_rsp_hs) begin
      r_rsp_valid  <= 1'b0;
    end
  end

`ifdef ARITH_SEQ_STATUS_CNT_EN
  logic [15:0] r_flag_count;

  // Saturating count of delivered responses with any status flag set.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset)
      r_flag_count <= '0;
    else if (w_rsp_hs && (r_rsp_status != '0) && (r_flag_count != 16'hFFFF))
      r_flag_count <= r_flag_count + 16'd1;
  end

  assign o_flag_count = r_flag_count;
`endif

  assign io_bus.o_cmd_ready  = (r_state == IDLE);
  assign io_bus.o_busy       = (r_state != IDLE);
  assign io_bus.o_arg_A      = r_arg_A;
  assign io_bus.o_arg_B      = r_arg_B;
  assign io_bus.o_op         = r_op;
  assign io_bus.o_rsp_valid  = r_rsp_valid;
  assign io_bus.o_rsp_result = r_rsp_result;
  assign io_bus.o_rsp_status = r_rsp_status;

endmodule
